window_2d_linebuf: RTL and testbench
====================================

// Module: window_2d_linebuf
// PURPOSE
//  Upstream feeder for the window_2d avg kernel. Accepts a raster-order pixel stream with valid/ready.
//  Buffers two image lines and emits every fully-populated 3x3 window to the avg stage with valid/ready.
//  Uses ap_start/ap_idle/ap_done frame control, so the dataflow monitors can sample it like avg.
// PARAMETERS
//  DATA_W  8   pixel width in bits
//  IMG_W   64  pixels per line; must be >= 3
//  IMG_H   64  lines per frame; must be >= 3
// PORTS
//  ap_clk     in   1        clock; all logic is rising-edge
//  ap_rst_n   in   1        asynchronous active-low reset
//  ap_start   in   1        frame start; sampled only in IDLE
//  ap_idle    out  1        1 while in IDLE
//  ap_done    out  1        1-cycle pulse when the last window of a frame is accepted
//  in_data    in   DATA_W   pixel, raster order
//  in_valid   in   1        pixel valid
//  in_ready   out  1        pixel accepted when in_valid&&in_ready
//  win_data   out  9*DATA_W window; element (r,c) at [(r*3+c)*DATA_W +: DATA_W]; r=0 top row, c=0 left column
//  win_valid  out  1        window valid
//  win_ready  in   1        consumer (avg) ready
//  win_last   out  1        qualifies the final window of the frame
// BEHAVIOUR
//  Reset values: ap_idle=1, ap_done=0, in_ready=0, win_valid=0, win_last=0, win_data=0.
//   Row/col counters=0. State=IDLE. Line-buffer RAM contents are not reset.
//  FSM: IDLE -(ap_start)-> RUN -(last pixel accepted)-> LAST -(win_valid&&win_ready)-> IDLE.
//   ap_done pulses on the IDLE-entry cycle.
//  in_ready = (state==RUN) && (!win_valid || win_ready). The whole pipeline stalls under backpressure.
//  Per accepted pixel P(y,x):
//   - Line buffers shift the column: lb1[x] <= lb0[x]; lb0[x] <= P.
//   - The 3x3 register shifts left by one column; the new right column is {lb1[x], lb0[x], P} (top..bottom).
//  Output latency 1 cycle: if y>=2 && x>=2, win_valid=1 on the next cycle.
//   The window's centre is (y-1,x-1).
//   win_last=1 iff (y,x)=(IMG_H-1,IMG_W-1).
//  win_valid/win_data/win_last hold stable until win_ready; win_valid drops after acceptance unless reloaded in the same cycle.
//  Counters: col wraps IMG_W-1 -> 0 and increments row; row clears after the last pixel.
//   Exactly (IMG_H-2)*(IMG_W-2) windows are produced per frame; no border or padded windows.
//  Column wrap: the 3x3 register is not cleared. Windows with x<2 are never emitted, so stale columns are harmless.
//  ap_start outside IDLE is ignored. The ap_done cycle is IDLE, so ap_start there starts the next frame (zero bubble).
//  Simultaneous win accept and new pixel accept in RUN: the output reloads in the same cycle. No bubble, no loss.
//  Reset mid-frame: all state returns to reset values immediately. The next frame after ap_start is correct
//   regardless of line-buffer contents.
//  Pixels presented while in_ready=0 are not consumed. in_valid in IDLE/LAST has no effect.
// CONFIGURATION
//  WIN2D_PERF_CNT_EN defined adds three outputs, all cleared on reset and on ap_start accept:
//   perf_stall_cyc  out 32  cycles with state!=IDLE && win_valid && !win_ready
//   perf_starve_cyc out 32  cycles with in_ready && !in_valid
//   perf_frame_cyc  out 32  cycles from ap_start accept through ap_done, inclusive
//   All three saturate at 2^32-1 and hold their value after ap_done until the next frame start.
//  WIN2D_PERF_CNT_EN undefined: these ports and counters do not exist; behaviour is otherwise identical.
// TESTING
//  1. IMG_W=4, IMG_H=4, pixel=y*4+x, win_ready=1, in_valid=1:
//     -> 4 windows. First = {0,1,2,4,5,6,8,9,10}; last = {5,6,7,9,10,11,13,14,15} with win_last=1.
//     -> One ap_done pulse.
//  2. Same frame with win_ready low for 5 cycles while the first window is valid:
//     -> win_data stable, in_ready=0 for those cycles; window sequence identical to test 1.
//  3. IMG_W=IMG_H=3, ap_start held high, two frames back-to-back:
//     -> One window per frame; ap_done twice; second frame accepts its first pixel the cycle after ap_done.
//  4. Assert ap_rst_n=0 after pixel 9 of a 4x4 frame, then restart with ramp data:
//     -> Reset values within the reset cycle; windows match test 1 exactly.
//  5. ap_start=1 pulsed in RUN, and in_valid=1 while IDLE:
//     -> No state change, no pixel consumed, ap_idle unaffected.
//  6. WIN2D_PERF_CNT_EN: 4x4 frame, win_ready low 3 cycles, 2 in_valid gaps:
//     -> perf_stall_cyc=3, perf_starve_cyc=2, perf_frame_cyc = total active cycles.

Source files
------------

// File: rtl/window_2d_linebuf_if.sv
// Frame control plus pixel-in / window-out streams for window_2d_linebuf.
// The design side takes the slave modport; the driving side (feeder or bench) takes master.
interface window_2d_linebuf_if #(
  parameter int DATA_W = 8
);
  logic                  ap_start;
  logic                  ap_idle;
  logic                  ap_done;
  logic [DATA_W-1:0]     in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic [9*DATA_W-1:0]   win_data;
  logic                  win_valid;
  logic                  win_ready;
  logic                  win_last;

  modport slave (
    input  ap_start, in_data, in_valid, win_ready,
    output ap_idle, ap_done, in_ready, win_data, win_valid, win_last
  );

  modport master (
    output ap_start, in_data, in_valid, win_ready,
    input  ap_idle, ap_done, in_ready, win_data, win_valid, win_last
  );
endinterface

// File: rtl/window_2d_linebuf.sv
// Two-line buffer feeding 3x3 windows to the avg stage, with ap_start/ap_idle/ap_done frame control.
// Define WIN2D_PERF_CNT_EN to add the stall/starve/frame-cycle performance counters.
module window_2d_linebuf #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 64,
  parameter int IMG_H  = 64
) (
  input  logic                ap_clk,
  input  logic                ap_rst_n,
  window_2d_linebuf_if.slave  bus
`ifdef WIN2D_PERF_CNT_EN
  ,
  output logic [31:0]         perf_stall_cyc,
  output logic [31:0]         perf_starve_cyc,
  output logic [31:0]         perf_frame_cyc
`endif
);

  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_LAST
  } state_e;

  state_e             state_q, state_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [DATA_W-1:0]  lb0_q [IMG_W];
  logic [DATA_W-1:0]  lb1_q [IMG_W];
  logic [DATA_W-1:0]  win_q [9];
  logic [DATA_W-1:0]  win_d [9];
  logic               vld_q, vld_d;
  logic               last_q, last_d;
  logic               done_q, done_d;

  logic               in_ready;
  logic               pix_acc;
  logic               start_acc;
  logic               last_pix;
  logic               emit;
  logic [DATA_W-1:0]  lb0_rd;
  logic [DATA_W-1:0]  lb1_rd;

  assign lb0_rd   = lb0_q[col_q];
  assign lb1_rd   = lb1_q[col_q];
  assign pix_acc  = bus.in_valid && in_ready;
  assign last_pix = (row_q == ROW_W'(IMG_H - 1)) && (col_q == COL_W'(IMG_W - 1));
  assign emit     = (row_q >= ROW_W'(2)) && (col_q >= COL_W'(2));

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    start_acc = 1'b0;
    done_d    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.ap_start) begin
          start_acc = 1'b1;
          state_d   = S_RUN;
        end
      end
      S_RUN: begin
        in_ready = !vld_q || bus.win_ready;
        if (bus.in_valid && in_ready && last_pix) state_d = S_LAST;
      end
      S_LAST: begin
        if (vld_q && bus.win_ready) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (pix_acc) begin
      if (col_q == COL_W'(IMG_W - 1)) begin
        col_d = '0;
        row_d = last_pix ? '0 : row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end
  end

  // Window shifts left one column per pixel; the fresh right column is lb1/lb0/pixel, top to bottom.
  always_comb begin
    win_d = win_q;
    if (pix_acc) begin
      for (int unsigned r = 0; r < 3; r++) begin
        win_d[r*3]     = win_q[r*3 + 1];
        win_d[r*3 + 1] = win_q[r*3 + 2];
      end
      win_d[2] = lb1_rd;
      win_d[5] = lb0_rd;
      win_d[8] = bus.in_data;
    end
  end

  // A reload in the accept cycle wins over the clear, so back-to-back windows need no bubble.
  always_comb begin
    vld_d  = vld_q;
    last_d = last_q;
    if (pix_acc && emit) begin
      vld_d  = 1'b1;
      last_d = last_pix;
    end else if (bus.win_ready) begin
      vld_d  = 1'b0;
      last_d = 1'b0;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q <= S_IDLE;
      col_q   <= '0;
      row_q   <= '0;
      vld_q   <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int unsigned i = 0; i < 9; i++) win_q[i] <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      vld_q   <= vld_d;
      last_q  <= last_d;
      done_q  <= done_d;
      win_q   <= win_d;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (pix_acc) begin
      lb1_q[col_q] <= lb0_rd;
      lb0_q[col_q] <= bus.in_data;
    end
  end

  always_comb begin
    for (int unsigned c = 0; c < 9; c++) bus.win_data[c*DATA_W +: DATA_W] = win_q[c];
  end

  assign bus.ap_idle   = (state_q == S_IDLE);
  assign bus.ap_done   = done_q;
  assign bus.in_ready  = in_ready;
  assign bus.win_valid = vld_q;
  assign bus.win_last  = last_q;

`ifdef WIN2D_PERF_CNT_EN
  logic [31:0] stall_q, starve_q, frame_q;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      stall_q  <= '0;
      starve_q <= '0;
      frame_q  <= '0;
    end else if (start_acc) begin
      stall_q  <= '0;
      starve_q <= '0;
      frame_q  <= 32'd1;
    end else begin
      if (state_q != S_IDLE && vld_q && !bus.win_ready && stall_q != '1) stall_q <= stall_q + 32'd1;
      if (in_ready && !bus.in_valid && starve_q != '1) starve_q <= starve_q + 32'd1;
      if ((state_q != S_IDLE || done_q) && frame_q != '1) frame_q <= frame_q + 32'd1;
    end
  end

  assign perf_stall_cyc  = stall_q;
  assign perf_starve_cyc = starve_q;
  assign perf_frame_cyc  = frame_q;
`endif

endmodule

// File: tb/tb_window_2d_linebuf.sv
// Randomized bench for window_2d_linebuf (4x4 frames) against a whole-frame window reference model.
module tb_window_2d_linebuf;
  localparam int W = 4;
  localparam int H = 4;
  localparam int N = W * H;

  logic ap_clk   = 1'b0;
  logic ap_rst_n = 1'b0;

  window_2d_linebuf_if #(.DATA_W(8)) bus ();

`ifdef WIN2D_PERF_CNT_EN
  logic [31:0] perf_stall, perf_starve, perf_frame;
`endif

  window_2d_linebuf #(
    .DATA_W (8),
    .IMG_W  (W),
    .IMG_H  (H)
  ) u_dut (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .bus      (bus)
`ifdef WIN2D_PERF_CNT_EN
    ,
    .perf_stall_cyc  (perf_stall),
    .perf_starve_cyc (perf_starve),
    .perf_frame_cyc  (perf_frame)
`endif
  );

  always #5 ap_clk = ~ap_clk;

  int unsigned errs   = 0;
  int unsigned checks = 0;

  logic [7:0]  img [H][W];
  logic [72:0] exp_q [$];
  bit          m_busy;
  bit          done_exp;
  int          pix;
  bit          prev_hold;
  logic [71:0] prev_data;
  logic [31:0] m_stall, m_starve, m_frame;

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errs++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Build the image and the full ordered list of interior 3x3 windows it must produce.
  task automatic new_frame(input bit ramp);
    logic [71:0] w;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        img[y][x] = ramp ? 8'(y * W + x) : 8'($urandom);
    exp_q.delete();
    for (int cy = 1; cy <= H - 2; cy++)
      for (int cx = 1; cx <= W - 2; cx++) begin
        for (int r = 0; r < 3; r++)
          for (int c = 0; c < 3; c++)
            w[(r*3 + c)*8 +: 8] = img[cy - 1 + r][cx - 1 + c];
        exp_q.push_back({(cy == H - 2 && cx == W - 2), w});
      end
  endtask

  task automatic model_reset();
    m_busy    = 0;
    done_exp  = 0;
    pix       = 0;
    prev_hold = 0;
    exp_q.delete();
    m_stall   = '0;
    m_starve  = '0;
    m_frame   = '0;
  endtask

  task automatic check_reset_vals();
    chk("rst_idle",      bus.ap_idle,   1);
    chk("rst_done",      bus.ap_done,   0);
    chk("rst_in_ready",  bus.in_ready,  0);
    chk("rst_win_valid", bus.win_valid, 0);
    chk("rst_win_last",  bus.win_last,  0);
    chk("rst_win_data",  bus.win_data,  0);
  endtask

  task automatic session(input int nframes, input int rdy_pct, input int vld_pct,
                         input bit ramp, input bit b2b, input bit stall_first, input int abort_pix);
    int  started  = 0;
    int  budget   = 0;
    int  stall_cnt = 0;
    bit  first_seen = 0;
    bit  exp_ir, in_hs, win_hs, start_now, next_busy, next_done;
    logic [72:0] e;
    while ((started < nframes || m_busy || done_exp) && budget < 2000) begin
      budget++;
      if (!m_busy) bus.ap_start = (started < nframes) && !(done_exp && !b2b);
      else         bus.ap_start = ($urandom_range(0, 3) == 0);
      bus.in_valid = ($urandom_range(1, 100) <= vld_pct);
      bus.in_data  = (m_busy && pix < N) ? img[pix / W][pix % W] : 8'($urandom);
      if (stall_first && !first_seen && bus.win_valid) begin
        first_seen = 1;
        stall_cnt  = 5;
      end
      if (stall_cnt > 0) begin
        bus.win_ready = 1'b0;
        stall_cnt--;
      end else begin
        bus.win_ready = ($urandom_range(1, 100) <= rdy_pct);
      end
      #1;
      exp_ir = m_busy && pix < N && (!bus.win_valid || bus.win_ready);
      chk("ap_idle",  bus.ap_idle,  !m_busy);
      chk("ap_done",  bus.ap_done,  done_exp);
      chk("in_ready", bus.in_ready, exp_ir);
      if (prev_hold) begin
        chk("hold_valid", bus.win_valid, 1);
        chk("hold_data",  bus.win_data,  prev_data);
      end
      in_hs     = bus.in_valid && exp_ir;
      win_hs    = bus.win_valid && bus.win_ready;
      start_now = bus.ap_start && !m_busy;
      next_busy = m_busy;
      next_done = 0;
      if (m_busy && bus.win_valid && !bus.win_ready) m_stall++;
      if (exp_ir && !bus.in_valid) m_starve++;
      if (start_now) begin
        m_stall  = '0;
        m_starve = '0;
        m_frame  = 32'd1;
      end else if (m_busy || done_exp) begin
        m_frame++;
      end
      if (win_hs) begin
        chk("win_avail", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("win_data", bus.win_data, e[71:0]);
          chk("win_last", bus.win_last, e[72]);
          if (e[72]) begin
            next_busy = 0;
            next_done = 1;
          end
        end
      end
      if (in_hs) pix++;
      if (start_now) begin
        chk("frame_drained", exp_q.size(), 0);
        next_busy  = 1;
        pix        = 0;
        started++;
        first_seen = 0;
        new_frame(ramp);
      end
      m_busy    = next_busy;
      done_exp  = next_done;
      prev_hold = bus.win_valid && !bus.win_ready;
      prev_data = bus.win_data;
      @(posedge ap_clk);
      #1;
      if (abort_pix > 0 && pix >= abort_pix) break;
    end
    chk("session_budget", budget < 2000, 1);
`ifdef WIN2D_PERF_CNT_EN
    if (abort_pix == 0) begin
      chk("perf_stall",  perf_stall,  m_stall);
      chk("perf_starve", perf_starve, m_starve);
      chk("perf_frame",  perf_frame,  m_frame);
    end
`endif
  endtask

  initial begin
    bus.ap_start  = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.win_ready = 1'b0;
    model_reset();
    #2;
    check_reset_vals();
    repeat (3) @(posedge ap_clk);
    #1;
    ap_rst_n = 1'b1;
    @(posedge ap_clk);
    #1;

    // Ramp frame, free-flowing.
    session(1, 100, 100, 1, 0, 0, 0);
    // Ramp frame with the first window held for five cycles.
    session(1, 100, 100, 1, 0, 1, 0);
    // Three frames back to back, random pixels.
    session(3, 100, 100, 0, 1, 0, 0);
    // Reset after nine pixels, then a clean ramp frame.
    session(1, 100, 100, 1, 0, 0, 9);
    ap_rst_n = 1'b0;
    #1;
    check_reset_vals();
    model_reset();
    bus.ap_start = 1'b0;
    @(posedge ap_clk);
    #1;
    ap_rst_n = 1'b1;
    @(posedge ap_clk);
    #1;
    session(1, 100, 100, 1, 0, 0, 0);
    // Random backpressure and input gaps.
    session(4, 60, 70, 0, 0, 0, 0);
    session(3, 40, 90, 0, 1, 1, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
